// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states, grant owners
// and default sizing, plus the owner-selection rule used in IDLE.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEF = 32;
  localparam int MAX_WAIT_DEF  = 15;
  localparam int WAIT_W        = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DM_ACC = 2'd1,
    IF_ACC = 2'd2
  } arbState_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } owner_e;

  // DM wins by default; IF wins a tie when DM owned the last completed access.
  function automatic owner_e pickOwner(input logic dmReq, input logic ifReq, input owner_e lastGrant);
    if (dmReq && ifReq) begin
      pickOwner = (lastGrant == OWNER_DM) ? OWNER_IF : OWNER_DM;
    end else if (dmReq) begin
      pickOwner = OWNER_DM;
    end else begin
      pickOwner = OWNER_IF;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Counts cycles an access spends waiting for mem_ready; flags expiry on the
// cycle the count reaches MAX_WAIT.
module wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WAIT_W-1:0] count_r;

  // Wait-cycle counter, cleared when a new access is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + WAIT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between the fetch stage and the memory stage,
// with alternating priority under contention and a sticky wait-timeout flag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_stall,
  input  logic                 dm_rd_en,
  input  logic                 dm_wr_en,
  input  logic [WORD_SIZE-1:0] dm_addr,
  input  logic [WORD_SIZE-1:0] dm_wdata,
  output logic [WORD_SIZE-1:0] dm_rdata,
  output logic                 dm_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 timeout_err
);

  arbState_e state_r;
  arbState_e nextState_s;
  owner_e    lastGrant_r;
  owner_e    pick_s;
  logic      dmReq_s;
  logic      grant_s;
  logic      done_s;
  logic      timerEn_s;
  logic      expired_s;

  assign dmReq_s   = dm_rd_en | dm_wr_en;
  assign timerEn_s = (state_r != IDLE) && !mem_ready;

  assign if_stall = if_req  & ~((state_r == IF_ACC) & mem_ready);
  assign dm_stall = dmReq_s & ~((state_r == DM_ACC) & mem_ready);

  wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_waitTimer (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_s),
    .enable (timerEn_s),
    .expired(expired_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state and per-cycle grant/complete decode
  always_comb begin
    nextState_s = state_r;
    grant_s     = 1'b0;
    done_s      = 1'b0;
    pick_s      = pickOwner(dmReq_s, if_req, lastGrant_r);
    case (state_r)
      IDLE: begin
        if (dmReq_s || if_req) begin
          grant_s = 1'b1;
          if (pick_s == OWNER_DM) begin
            nextState_s = DM_ACC;
          end else begin
            nextState_s = IF_ACC;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      DM_ACC, IF_ACC: begin
        if (mem_ready) begin
          done_s      = 1'b1;
          nextState_s = IDLE;
        end else if (expired_s) begin
          // Abandon the access; the requester is still stalled and re-arbitrates.
          nextState_s = IDLE;
        end else begin
          nextState_s = state_r;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Shared-port request, latched address/data/we and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant_s) begin
        mem_req <= 1'b1;
        if (pick_s == OWNER_DM) begin
          mem_we    <= dm_wr_en;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end else if (done_s || expired_s) begin
        mem_req <= 1'b0;
      end else begin
        mem_req <= mem_req;
      end
      if (expired_s) begin
        timeout_err <= 1'b1;
      end else begin
        timeout_err <= timeout_err;
      end
    end
  end

  // Read-result capture and record of the last completed grant
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata    <= '0;
      dm_rdata    <= '0;
      lastGrant_r <= OWNER_IF;
    end else if (done_s) begin
      if (state_r == IF_ACC) begin
        if_rdata    <= mem_rdata;
        lastGrant_r <= OWNER_IF;
      end else begin
        lastGrant_r <= OWNER_DM;
        if (!mem_we) begin
          dm_rdata <= mem_rdata;
        end else begin
          dm_rdata <= dm_rdata;
        end
      end
    end else begin
      lastGrant_r <= lastGrant_r;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int WS = 32;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst, if_req, dm_rd_en, dm_wr_en, mem_ready;
  logic [WS-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [WS-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic          if_stall, dm_stall, mem_req, mem_we, timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(WS), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic          req;
    logic          we;
    logic [WS-1:0] addr;
    logic [WS-1:0] wdata;
    logic [WS-1:0] ifData;
    logic [WS-1:0] dmData;
    logic          ifStall;
    logic          dmStall;
    logic          to;
  } outs_t;

  typedef struct {
    logic          rst, ifReq;
    logic [WS-1:0] ifAddr;
    logic          dmRd, dmWr;
    logic [WS-1:0] dmAddr, dmWdata;
    logic          rdy;
    logic [WS-1:0] rdata;
    outs_t         exp;
  } vec_t;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model: one outstanding access at a time, described as a transaction.
  bit            mBusy, mOwnerDm, mLastDm, mReq, mWe, mTo;
  int            mWait;
  logic [WS-1:0] mAddr, mWdata, mIfData, mDmData;

  function automatic outs_t actualOuts();
    return '{req:mem_req, we:mem_we, addr:mem_addr, wdata:mem_wdata, ifData:if_rdata,
             dmData:dm_rdata, ifStall:if_stall, dmStall:dm_stall, to:timeout_err};
  endfunction

  function automatic outs_t modelOuts();
    logic ifDone, dmDone;
    ifDone = mBusy && !mOwnerDm && mem_ready;
    dmDone = mBusy &&  mOwnerDm && mem_ready;
    return '{req:mReq, we:mWe, addr:mAddr, wdata:mWdata, ifData:mIfData, dmData:mDmData,
             ifStall:(if_req && !ifDone), dmStall:((dm_rd_en || dm_wr_en) && !dmDone), to:mTo};
  endfunction

  task automatic modelEdge();
    if (rst) begin
      mBusy = 1'b0; mOwnerDm = 1'b0; mLastDm = 1'b0; mReq = 1'b0; mWe = 1'b0; mTo = 1'b0;
      mWait = 0; mAddr = '0; mWdata = '0; mIfData = '0; mDmData = '0;
    end else if (!mBusy) begin
      if (dm_rd_en || dm_wr_en || if_req) begin
        mOwnerDm = (dm_rd_en || dm_wr_en) && !(if_req && mLastDm);
        mBusy = 1'b1; mWait = 0; mReq = 1'b1;
        if (mOwnerDm) begin
          mAddr = dm_addr; mWdata = dm_wdata; mWe = dm_wr_en;
        end else begin
          mAddr = if_addr; mWdata = '0; mWe = 1'b0;
        end
      end
    end else if (mem_ready) begin
      if (!mOwnerDm) mIfData = mem_rdata;
      else if (!mWe) mDmData = mem_rdata;
      mLastDm = mOwnerDm; mBusy = 1'b0; mReq = 1'b0;
    end else begin
      mWait++;
      if (mWait == MW) begin
        mBusy = 1'b0; mReq = 1'b0; mTo = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic setIn(input logic r, input logic ir, input logic [WS-1:0] ia, input logic dr,
                       input logic dw, input logic [WS-1:0] da, input logic [WS-1:0] dwd,
                       input logic rdy, input logic [WS-1:0] rd);
    rst = r; if_req = ir; if_addr = ia; dm_rd_en = dr; dm_wr_en = dw;
    dm_addr = da; dm_wdata = dwd; mem_ready = rdy; mem_rdata = rd;
  endtask

  task automatic checkOuts(input string name, input outs_t e);
    outs_t a;
    a = actualOuts();
    vecCount++;
    if (a !== e) begin
      missCount++;
      $display("FAIL %s: got req=%0b we=%0b addr=%h wdata=%h ifd=%h dmd=%h ifst=%0b dmst=%0b to=%0b; expected req=%0b we=%0b addr=%h wdata=%h ifd=%h dmd=%h ifst=%0b dmst=%0b to=%0b",
               name, a.req, a.we, a.addr, a.wdata, a.ifData, a.dmData, a.ifStall, a.dmStall, a.to,
               e.req, e.we, e.addr, e.wdata, e.ifData, e.dmData, e.ifStall, e.dmStall, e.to);
    end
  endtask

  task automatic checkVal(input string name, input logic [WS-1:0] got, input logic [WS-1:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t row(input logic r, input logic ir, input logic [WS-1:0] ia,
                               input logic dr, input logic dw, input logic [WS-1:0] da,
                               input logic [WS-1:0] dwd, input logic rdy, input logic [WS-1:0] rd,
                               input logic eq, input logic ew, input logic [WS-1:0] ea,
                               input logic [WS-1:0] ewd, input logic [WS-1:0] eid,
                               input logic [WS-1:0] edd, input logic eis, input logic eds,
                               input logic eto);
    vec_t v;
    v.rst = r; v.ifReq = ir; v.ifAddr = ia; v.dmRd = dr; v.dmWr = dw;
    v.dmAddr = da; v.dmWdata = dwd; v.rdy = rdy; v.rdata = rd;
    v.exp = '{req:eq, we:ew, addr:ea, wdata:ewd, ifData:eid, dmData:edd, ifStall:eis, dmStall:eds, to:eto};
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    setIn(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    step();
    step();

    // Columns: rst ifReq ifAddr dmRd dmWr dmAddr dmWdata rdy rdata | req we addr wdata ifd dmd ifst dmst to
    // Lone fetch at 0x40, ready one cycle after mem_req.
    tbl[0]  = row(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h0,    32'h0,    1'b0, 1'b0, 1'b0);
    tbl[1]  = row(1'b0, 1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h0,    32'h0,    1'b1, 1'b0, 1'b0);
    tbl[2]  = row(1'b0, 1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,    1'b1, 1'b0, 32'h40,  32'h0,        32'h0,    32'h0,    1'b1, 1'b0, 1'b0);
    tbl[3]  = row(1'b0, 1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h13,   1'b1, 1'b0, 32'h40,  32'h0,        32'h0,    32'h0,    1'b0, 1'b0, 1'b0);
    tbl[4]  = row(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h40,  32'h0,        32'h13,   32'h0,    1'b0, 1'b0, 1'b0);
    // Write and fetch together from reset: DM first, then IF; dm_rdata untouched.
    tbl[5]  = row(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,    1'b0, 1'b0, 32'h40,  32'h0,        32'h13,   32'h0,    1'b1, 1'b1, 1'b0);
    tbl[6]  = row(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h0,    32'h0,    1'b1, 1'b1, 1'b0);
    tbl[7]  = row(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,    1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,    32'h0,    1'b1, 1'b1, 1'b0);
    tbl[8]  = row(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h55,   1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0);
    tbl[9]  = row(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0);
    tbl[10] = row(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'hA5A5, 1'b1, 1'b0, 32'h200, 32'h0,        32'h0,    32'h0,    1'b0, 1'b0, 1'b0);
    tbl[11] = row(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h200, 32'h0,        32'hA5A5, 32'h0,    1'b0, 1'b0, 1'b0);
    // Read+write together is a write; a following read updates dm_rdata.
    tbl[12] = row(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 32'h1234,     1'b0, 32'h0,    1'b0, 1'b0, 32'h200, 32'h0,        32'hA5A5, 32'h0,    1'b0, 1'b1, 1'b0);
    tbl[13] = row(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 32'h1234,     1'b1, 32'h77,   1'b1, 1'b1, 32'h300, 32'h1234,     32'hA5A5, 32'h0,    1'b0, 1'b0, 1'b0);
    tbl[14] = row(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h304, 32'h1234,     1'b0, 32'h0,    1'b0, 1'b1, 32'h300, 32'h1234,     32'hA5A5, 32'h0,    1'b0, 1'b1, 1'b0);
    tbl[15] = row(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h304, 32'h1234,     1'b1, 32'hCAFE, 1'b1, 1'b0, 32'h304, 32'h1234,     32'hA5A5, 32'h0,    1'b0, 1'b0, 1'b0);
    tbl[16] = row(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h304, 32'h1234,     32'hA5A5, 32'hCAFE, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      setIn(tbl[i].rst, tbl[i].ifReq, tbl[i].ifAddr, tbl[i].dmRd, tbl[i].dmWr,
            tbl[i].dmAddr, tbl[i].dmWdata, tbl[i].rdy, tbl[i].rdata);
      #1;
      checkOuts($sformatf("row%0d", i), tbl[i].exp);
      step();
    end

    // Continuous contention: grants must alternate DM, IF, DM, IF.
    begin : altSeq
      logic [WS-1:0] seen[$];
      logic [WS-1:0] expA;
      int            budget;
      setIn(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      step();
      setIn(1'b0, 1'b1, 32'h2000, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 32'h0);
      budget = 0;
      while (seen.size() < 4 && budget < 40) begin
        mem_ready = mem_req;
        mem_rdata = $urandom;
        if (mem_req) seen.push_back(mem_addr);
        #1;
        step();
        budget++;
      end
      for (int k = 0; k < 4; k++) begin
        expA = (k % 2 == 0) ? 32'h1000 : 32'h2000;
        if (k < seen.size()) begin
          checkVal($sformatf("grant%0d", k), seen[k], expA);
        end else begin
          vecCount++;
          missCount++;
          $display("FAIL grant%0d: got none expected %h", k, expA);
        end
      end
    end

    // mem_ready held low: mem_req for exactly MW cycles, sticky flag, re-grant.
    begin : toSeq
      int cnt;
      setIn(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      step();
      setIn(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      step();
      cnt = 0;
      while (mem_req === 1'b1 && cnt < 40) begin
        cnt++;
        step();
      end
      checkVal("timeoutLen", cnt, MW);
      checkVal("timeoutFlag", {31'h0, timeout_err}, 32'h1);
      checkVal("stallHeld", {31'h0, if_stall}, 32'h1);
      step();
      checkVal("regrantReq", {31'h0, mem_req}, 32'h1);
      checkVal("regrantAddr", mem_addr, 32'h80);
      mem_ready = 1'b1;
      mem_rdata = 32'h99;
      step();
      mem_ready = 1'b0;
      if_req    = 1'b0;
      #1;
      checkVal("afterTimeoutData", if_rdata, 32'h99);
      checkVal("timeoutSticky", {31'h0, timeout_err}, 32'h1);
    end

    // Reset in the middle of a DM access clears everything.
    setIn(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 32'h5, 1'b0, 32'h0);
    step();
    step();
    checkVal("dmInFlight", {30'h0, mem_req, mem_we}, 32'h3);
    setIn(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    step();
    #1;
    checkOuts("midAccessReset", '0);

    // Randomized traffic; the second half starves mem_ready to provoke timeouts.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 249) == 0);
      if_req    = ($urandom_range(0, 2) != 0);
      if_addr   = $urandom;
      dm_rd_en  = ($urandom_range(0, 2) == 0);
      dm_wr_en  = ($urandom_range(0, 3) == 0);
      dm_addr   = $urandom;
      dm_wdata  = $urandom;
      mem_ready = (c < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      mem_rdata = $urandom;
      #1;
      checkOuts("random", modelOuts());
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
